// File: rtl/griffin_pkg.sv
// Shared types and defaults for the Griffin sponge controller.
// The field is the BN254 scalar field; the state is STATE_SIZE field elements.
package griffin_pkg;

   localparam int DEFAULT_N_BITS     = 254;
   localparam int DEFAULT_STATE_SIZE = 3;
   localparam int DEFAULT_RATE       = 2;

   localparam logic [DEFAULT_N_BITS-1:0] DEFAULT_PRIME =
      254'h30644e72e131a029b85045b68181585d2833e84879b9709143e1f593f0000001;

   typedef logic [DEFAULT_N_BITS-1:0] fe_t;
   typedef fe_t [DEFAULT_STATE_SIZE-1:0] state_t;

   typedef enum logic [2:0] {
      ST_ABSORB,
      ST_PAD,
      ST_START,
      ST_WAIT,
      ST_SQUEEZE
   } sponge_state_e;

endpackage

// File: rtl/mod_add.sv
// Combinational modular addition: y = (a + b) mod p for operands already below p.
// A single conditional subtraction suffices because a + b < 2p.
module mod_add #(
   parameter int                N_BITS        = 254,
   parameter logic [N_BITS-1:0] PRIME_MODULUS = '1
) (
   input  logic [N_BITS-1:0] a,
   input  logic [N_BITS-1:0] b,
   output logic [N_BITS-1:0] y
);

   logic [N_BITS:0] sum;
   logic [N_BITS:0] diff;
   logic            wrap;

   always_comb begin
      sum  = {1'b0, a} + {1'b0, b};
      diff = sum - {1'b0, PRIME_MODULUS};
      wrap = (sum >= {1'b0, PRIME_MODULUS});
      y    = wrap ? diff[N_BITS-1:0] : sum[N_BITS-1:0];
   end

endmodule

// File: rtl/griffin_sponge.sv
// Sponge controller around the Griffin permutation: absorbs field elements into the
// rate lanes, pads the final block, drives the permutation and returns lane 0 as digest.
module griffin_sponge
   import griffin_pkg::*;
#(
   parameter int                N_BITS        = DEFAULT_N_BITS,
   parameter logic [N_BITS-1:0] PRIME_MODULUS = N_BITS'(DEFAULT_PRIME),
   parameter int                STATE_SIZE    = DEFAULT_STATE_SIZE,
   parameter int                RATE          = DEFAULT_RATE,
   parameter logic [N_BITS-1:0] CAPACITY_IV   = '0
) (
   input  logic                                 clk,
   input  logic                                 reset,
   input  logic                                 in_valid,
   output logic                                 in_ready,
   input  logic [N_BITS-1:0]                    in_data,
   input  logic                                 in_last,
   output logic                                 perm_start,
   output logic [STATE_SIZE-1:0][N_BITS-1:0]    perm_state_out,
   input  logic [STATE_SIZE-1:0][N_BITS-1:0]    perm_state_in,
   input  logic                                 perm_done,
   output logic                                 out_valid,
   input  logic                                 out_ready,
   output logic [N_BITS-1:0]                    out_digest
);

   localparam int              IDX_W    = (STATE_SIZE > 1) ? $clog2(STATE_SIZE) : 1;
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(RATE - 1);

   // Handshake rule: a transfer happens on a rising edge where valid and ready are
   // both high; ready never depends combinationally on valid.
   sponge_state_e                     state_q, state_nx;
   logic [STATE_SIZE-1:0][N_BITS-1:0] s_q;
   logic [STATE_SIZE-1:0][N_BITS-1:0] iv_state;
   logic [IDX_W-1:0]                  idx_q;
   logic [IDX_W-1:0]                  lane_sel;
   logic                              last_blk_q;
   logic                              rdy_en_q;
   logic                              accept;
   logic                              pad_needed;
   logic [N_BITS-1:0]                 add_a;
   logic [N_BITS-1:0]                 add_b;
   logic [N_BITS-1:0]                 add_y;

   always_comb begin
      for (int i = 0; i < STATE_SIZE; i++) begin
         iv_state[i] = (i < RATE) ? '0 : CAPACITY_IV;
      end
   end

   // One adder serves both absorption and the +1 padding; PAD steers it to lane idx+1.
   mod_add #(
      .N_BITS        (N_BITS),
      .PRIME_MODULUS (PRIME_MODULUS)
   ) u_mod_add (
      .a (add_a),
      .b (add_b),
      .y (add_y)
   );

   assign add_a          = s_q[lane_sel];
   assign accept         = in_valid & in_ready;
   assign pad_needed     = (idx_q < LAST_IDX);
   assign perm_state_out = s_q;

   // State register and datapath.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q    <= ST_ABSORB;
         s_q        <= iv_state;
         idx_q      <= '0;
         last_blk_q <= 1'b0;
         rdy_en_q   <= 1'b0;
      end else begin
         state_q  <= state_nx;
         rdy_en_q <= 1'b1;
         case (state_q)
            ST_ABSORB: begin
               if (accept) begin
                  s_q[idx_q] <= add_y;
                  if (in_last) begin
                     last_blk_q <= 1'b1;
                  end else if (idx_q != LAST_IDX) begin
                     idx_q <= idx_q + IDX_W'(1);
                  end
               end
            end
            ST_PAD: begin
               if (pad_needed) begin
                  s_q[lane_sel] <= add_y;
               end
            end
            ST_WAIT: begin
               if (perm_done) begin
                  s_q   <= perm_state_in;
                  idx_q <= '0;
               end
            end
            ST_SQUEEZE: begin
               if (out_ready) begin
                  s_q        <= iv_state;
                  idx_q      <= '0;
                  last_blk_q <= 1'b0;
               end
            end
            default: ;
         endcase
      end
   end

   // Next-state logic.
   always_comb begin
      state_nx = state_q;
      case (state_q)
         ST_ABSORB: begin
            if (accept) begin
               if (in_last) begin
                  state_nx = ST_PAD;
               end else if (idx_q == LAST_IDX) begin
                  state_nx = ST_START;
               end
            end
         end
         ST_PAD:   state_nx = ST_START;
         ST_START: state_nx = ST_WAIT;
         ST_WAIT: begin
            if (perm_done) begin
               state_nx = last_blk_q ? ST_SQUEEZE : ST_ABSORB;
            end
         end
         ST_SQUEEZE: begin
            if (out_ready) begin
               state_nx = ST_ABSORB;
            end
         end
         default: state_nx = ST_ABSORB;
      endcase
   end

   // Outputs and adder operand steering.
   always_comb begin
      in_ready   = 1'b0;
      perm_start = 1'b0;
      out_valid  = 1'b0;
      out_digest = '0;
      lane_sel   = idx_q;
      add_b      = in_data;
      case (state_q)
         ST_ABSORB: in_ready = rdy_en_q;
         ST_PAD: begin
            lane_sel = idx_q + IDX_W'(1);
            add_b    = N_BITS'(1);
         end
         ST_START: perm_start = 1'b1;
         ST_SQUEEZE: begin
            out_valid  = 1'b1;
            out_digest = s_q[0];
         end
         default: ;
      endcase
   end

endmodule

// File: tb/tb_griffin_sponge.sv
// Directed bench for griffin_sponge with an identity-permutation stub answering
// 5 cycles after perm_start; a negedge monitor checks against expected queues.
module tb_griffin_sponge;
   import griffin_pkg::*;

   localparam int NB = DEFAULT_N_BITS;
   localparam int SS = DEFAULT_STATE_SIZE;
   localparam int CW = NB * SS;

   logic   clk = 1'b0;
   logic   reset = 1'b1;
   logic   in_valid = 1'b0;
   logic   in_ready;
   fe_t    in_data = '0;
   logic   in_last = 1'b0;
   logic   perm_start;
   state_t perm_state_out;
   state_t perm_state_in;
   logic   perm_done;
   logic   out_valid;
   logic   out_ready = 1'b1;
   fe_t    out_digest;

   logic [CW-1:0] exp_perm_q[$];
   logic [NB-1:0] exp_dig_q[$];

   int checks = 0;
   int failures = 0;
   int cyc = 0;
   int acc_cyc = 0;
   logic acc_last = 1'b0;
   int n_starts = 0;

   // Permutation stub.
   int     stub_cnt = 0;
   state_t stub_cap = '0;
   logic   inj_done = 1'b0;
   state_t inj_state = '0;

   griffin_sponge dut (
      .clk            (clk),
      .reset          (reset),
      .in_valid       (in_valid),
      .in_ready       (in_ready),
      .in_data        (in_data),
      .in_last        (in_last),
      .perm_start     (perm_start),
      .perm_state_out (perm_state_out),
      .perm_state_in  (perm_state_in),
      .perm_done      (perm_done),
      .out_valid      (out_valid),
      .out_ready      (out_ready),
      .out_digest     (out_digest)
   );

   // Clock and cycle counter.
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   always @(posedge clk) begin
      if (perm_start) begin
         stub_cnt <= 5;
         stub_cap <= perm_state_out;
      end else if (stub_cnt != 0) begin
         stub_cnt <= stub_cnt - 1;
      end
   end

   assign perm_done     = (stub_cnt == 1) | inj_done;
   assign perm_state_in = inj_done ? inj_state : stub_cap;

   task automatic chk(input string name, input logic [CW-1:0] act, input logic [CW-1:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s act=%0h exp=%0h", name, act, exp);
      end
   endtask

   function automatic state_t mk(input fe_t a, input fe_t b, input fe_t c);
      state_t s;
      s[0] = a;
      s[1] = b;
      s[2] = c;
      return s;
   endfunction

   // Monitor: compares DUT outputs against the expected queues.
   always @(negedge clk) begin
      if (!reset) begin
         if (in_valid && in_ready) begin
            acc_cyc  = cyc;
            acc_last = in_last;
         end
         if (perm_start) begin
            n_starts++;
            chk("perm_start_delay", CW'(cyc - acc_cyc), CW'(acc_last ? 2 : 1));
            if (exp_perm_q.size() == 0) begin
               chk("perm_start_unexpected", CW'(1), CW'(0));
            end else begin
               chk("perm_state_out", perm_state_out, exp_perm_q.pop_front());
            end
         end
         if (out_valid && out_ready) begin
            if (exp_dig_q.size() == 0) begin
               chk("digest_unexpected", CW'(1), CW'(0));
            end else begin
               chk("digest", CW'(out_digest), CW'(exp_dig_q.pop_front()));
            end
         end
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic send(input fe_t d, input logic l);
      int t = 0;
      in_valid = 1'b1;
      in_data  = d;
      in_last  = l;
      while (!in_ready && t < 200) begin
         step();
         t++;
      end
      chk("in_ready_wait", CW'(t < 200), CW'(1));
      step();
      in_valid = 1'b0;
      in_last  = 1'b0;
   endtask

   task automatic drain();
      int t = 0;
      while ((exp_dig_q.size() != 0 || exp_perm_q.size() != 0) && t < 500) begin
         step();
         t++;
      end
      chk("drain", CW'(t < 500), CW'(1));
      step();
   endtask

   task automatic pulse_spurious_done();
      inj_state = mk(fe_t'(123), fe_t'(45), fe_t'(67));
      inj_done  = 1'b1;
      step();
      inj_done  = 1'b0;
      step();
   endtask

   initial begin
      fe_t pm1;
      int t;
      pm1 = DEFAULT_PRIME - fe_t'(1);

      // Reset values.
      repeat (3) step();
      @(negedge clk);
      chk("rst_in_ready", CW'(in_ready), CW'(0));
      chk("rst_perm_start", CW'(perm_start), CW'(0));
      chk("rst_out_valid", CW'(out_valid), CW'(0));
      chk("rst_out_digest", CW'(out_digest), CW'(0));
      chk("rst_perm_state", perm_state_out, mk('0, '0, '0));
      @(posedge clk);
      #1 reset = 1'b0;
      @(negedge clk);
      chk("in_ready_pre_rise", CW'(in_ready), CW'(0));
      @(negedge clk);
      chk("in_ready_rise", CW'(in_ready), CW'(1));
      step();

      // Single element, padded.
      exp_perm_q.push_back(mk(fe_t'(5), fe_t'(1), '0));
      exp_dig_q.push_back(fe_t'(5));
      send(fe_t'(5), 1'b1);
      drain();

      // Full final block, no padding.
      exp_perm_q.push_back(mk(fe_t'(3), fe_t'(4), '0));
      exp_dig_q.push_back(fe_t'(3));
      send(fe_t'(3), 1'b0);
      send(fe_t'(4), 1'b1);
      drain();

      // Two blocks with modular wrap in lane 0.
      exp_perm_q.push_back(mk(pm1, '0, '0));
      exp_perm_q.push_back(mk(fe_t'(1), fe_t'(1), '0));
      exp_dig_q.push_back(fe_t'(1));
      send(pm1, 1'b0);
      send('0, 1'b0);
      send(fe_t'(2), 1'b1);
      drain();

      // Digest back-pressure.
      exp_perm_q.push_back(mk(fe_t'(11), fe_t'(1), '0));
      exp_dig_q.push_back(fe_t'(11));
      out_ready = 1'b0;
      send(fe_t'(11), 1'b1);
      t = 0;
      while (!out_valid && t < 100) begin
         step();
         t++;
      end
      chk("out_valid_wait", CW'(t < 100), CW'(1));
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         chk("hold_out_valid", CW'(out_valid), CW'(1));
         chk("hold_out_digest", CW'(out_digest), CW'(11));
         chk("hold_in_ready", CW'(in_ready), CW'(0));
      end
      step();
      out_ready = 1'b1;
      exp_perm_q.push_back(mk(fe_t'(7), fe_t'(1), '0));
      exp_dig_q.push_back(fe_t'(7));
      step();
      send(fe_t'(7), 1'b1);
      drain();

      // Reset during WAIT; the stub's late perm_done must be ignored.
      exp_perm_q.push_back(mk(fe_t'(6), fe_t'(1), '0));
      send(fe_t'(6), 1'b1);
      step();
      step();
      step();
      reset = 1'b1;
      step();
      reset = 1'b0;
      repeat (8) step();
      @(negedge clk);
      chk("abort_in_ready", CW'(in_ready), CW'(1));
      chk("abort_out_valid", CW'(out_valid), CW'(0));
      chk("abort_state", perm_state_out, mk('0, '0, '0));
      step();
      exp_perm_q.push_back(mk(fe_t'(9), fe_t'(1), '0));
      exp_dig_q.push_back(fe_t'(9));
      send(fe_t'(9), 1'b1);
      drain();

      // Spurious perm_done while absorbing.
      pulse_spurious_done();
      @(negedge clk);
      chk("spur_idle_state", perm_state_out, mk('0, '0, '0));
      chk("spur_idle_ready", CW'(in_ready), CW'(1));
      step();
      exp_perm_q.push_back(mk(fe_t'(20), fe_t'(30), '0));
      exp_dig_q.push_back(fe_t'(20));
      send(fe_t'(20), 1'b0);
      pulse_spurious_done();
      @(negedge clk);
      chk("spur_mid_state", perm_state_out, mk(fe_t'(20), '0, '0));
      step();
      send(fe_t'(30), 1'b1);
      drain();

      repeat (10) step();
      chk("start_count", CW'(n_starts), CW'(9));
      chk("perm_q_empty", CW'(exp_perm_q.size()), CW'(0));
      chk("dig_q_empty", CW'(exp_dig_q.size()), CW'(0));

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/griffin_sponge.md
# griffin_sponge

Sponge-mode controller that sits directly upstream and downstream of the Griffin permutation core. It absorbs a stream of field elements into the rate lanes of a STATE_SIZE-element state using modular addition, and applies message padding. It launches the permutation through a start/done handshake, takes back the permuted state, and after the final block presents state lane 0 as the digest.

## Interface
- N_BITS, 254, field element width
- PRIME_MODULUS, BN254 scalar prime (254'h30644e72…0000001), field modulus p
- STATE_SIZE, 3, permutation width in elements
- RATE, 2, rate lanes (lanes 0..RATE-1); capacity = STATE_SIZE-RATE
- CAPACITY_IV, 0, initial value of every capacity lane
- clk  in  1  clock
- reset  in  1  synchronous, active-high
- in_valid  in  1  input element valid
- in_ready  out  1  block accepts an input element
- in_data  in  N_BITS  message element, must be < p
- in_last  in  1  marks the final element of a message
- perm_start  out  1  one-cycle pulse that launches the permutation
- perm_state_out  out  N_BITS x STATE_SIZE  state sent to the permutation, stable from perm_start until perm_done
- perm_state_in  in  N_BITS x STATE_SIZE  permuted state, sampled when perm_done is high
- perm_done  in  1  permutation result valid (single-cycle pulse)
- out_valid  out  1  digest valid
- out_ready  in  1  consumer accepts the digest
- out_digest  out  N_BITS  state lane 0 after the final permutation

## Operation
- State register S[0..STATE_SIZE-1], lane index idx in 0..RATE-1, flag last_blk.
- After reset and after each digest handoff: S[0..RATE-1]=0, S[RATE..]=CAPACITY_IV, idx=0.
- FSM: ABSORB → PAD → START → WAIT → (ABSORB | SQUEEZE).
- ABSORB, in_ready=1:
  - On in_valid: S[idx] ← (S[idx]+in_data) mod p.
  - If in_last: last_blk ← 1 and go to PAD.
  - Else if idx=RATE-1: go to START.
  - Else idx ← idx+1.
- PAD, one cycle: if the last element landed at idx<RATE-1, S[idx+1] ← (S[idx+1]+1) mod p. A full final block gets no padding. Then go to START.
- START: perm_start=1 for exactly one cycle; perm_state_out mirrors S. Go to WAIT.
- WAIT: on perm_done, S ← perm_state_in and idx ← 0. Go to SQUEEZE if last_blk, else ABSORB.
- SQUEEZE: out_valid=1 and out_digest=S[0], held until out_ready. When out_valid&&out_ready, reinitialise S, clear last_blk, go to ABSORB.
- Modular add: compute the (N_BITS+1)-bit sum; if sum ≥ p, subtract p. Operands < p give a result < p. Inputs ≥ p are illegal and the result is undefined.
- perm_done outside WAIT is ignored.
- An empty message is not representable; a message is at least one element.

## Timing
- Reset values: in_ready=0, perm_start=0, out_valid=0, out_digest=0, perm_state_out=IV state, FSM=ABSORB. in_ready rises the cycle after reset deasserts.
- Element accepted on cycle t is visible in S at t+1.
- Non-final full block: perm_start asserted 1 cycle after the accepting edge of the last rate element.
- Final block: PAD adds 1 cycle; perm_start asserted 2 cycles after in_last is accepted.
- perm_done on cycle t: S updated at t+1. in_ready=1 or out_valid=1 from t+1.
- Throughput per block = RATE input cycles + 1 (START) + permutation latency (+1 PAD on the final block).
- Back-to-back messages: a new message is accepted the cycle after the digest handshake.
- Reset mid-operation, including WAIT: abort to the initial state; a stale perm_done arriving afterwards is ignored.

## Structure
- Package griffin_pkg holds:
  - the field-element typedef (logic [N_BITS-1:0]);
  - the state-array typedef;
  - the default PRIME_MODULUS;
  - the FSM state enum.
- Sub-module mod_add (combinational a+b mod p, parameterised on N_BITS and PRIME_MODULUS) is instantiated once for absorb and reused for the +1 padding; the two cases are muxed.

## Test plan
Bench uses an identity-permutation stub with perm_done 5 cycles after perm_start.
- Message [5], in_last on element 0, IV=0 → perm_state_out=[5,1,0] at perm_start; digest 5.
- Message [3,4], last on 4 → no padding, perm_state_out=[3,4,0], digest 3; perm_start exactly 2 cycles after in_last acceptance.
- Message [p-1,0,2] → block 1 [p-1,0,0]; block 2: lane0=(p-1+2) mod p=1, lane1=0+1=1; digest 1 (wrap path).
- Hold out_ready=0 for 10 cycles → out_valid and out_digest stable, in_ready=0; after the handshake the next message [7] gives digest 7.
- Assert reset in WAIT, then a stub perm_done 2 cycles later → ignored. Next message [9] gives perm_state_out=[9,1,0] and digest 9.
- Spurious perm_done pulse in ABSORB → no change to S; perm_start count equals block count.
